cache_req_issuer: RTL
=====================

# cache_req_issuer

Upstream stage of `cache_controller`: accepts CPU load/store requests over a valid/ready handshake, buffers them in a small FIFO, and issues them one at a time on the controller's `cpu_re`/`cpu_we`/`cpu_addr`/`cpu_wdata` level interface. It holds each request until the controller's one-cycle `ready` pulse and returns the result over a response handshake. A watchdog aborts requests that receive no `ready` pulse.

## Interface
Parameters:
- `ADDRESSLENGTH`, 16, address width
- `DATALENGTH`, 32, data width
- `DEPTH`, 4, request FIFO entries, power of 2, ≥2
- `TIMEOUT`, 64, max cycles in ISSUE before abort, ≥4

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `req_valid`  in  1  request offered
- `req_ready`  out  1  FIFO can accept
- `req_we`  in  1  1=store, 0=load
- `req_addr`  in  ADDRESSLENGTH  request address
- `req_wdata`  in  DATALENGTH  store data
- `rsp_valid`  out  1  response available
- `rsp_ready`  in  1  consumer accepts response
- `rsp_we`  out  1  echo of request `we`
- `rsp_rdata`  out  DATALENGTH  load data (0 for stores/errors)
- `rsp_err`  out  1  request timed out
- `mem_re`, `mem_we`  out  1  to controller `cpu_re`/`cpu_we`
- `mem_addr`  out  ADDRESSLENGTH  to controller `cpu_addr`
- `mem_wdata`  out  DATALENGTH  to controller `cpu_wdata`
- `mem_rdata`  in  DATALENGTH  from controller `cpu_rdata`
- `mem_ready`  in  1  from controller `ready`, one-cycle pulse
- `fifo_count`  out  $clog2(DEPTH)+1  occupied entries

## Operation
- FIFO: push when `req_valid && req_ready`. `req_ready = !full`, from registered count only, so no push-through when full. Pointers carry an extra wrap bit; full = pointer MSBs differ, low bits equal.
- FSM states:
  - IDLE: if FIFO non-empty, pop head into issue registers (`we`, `addr`, `wdata`), clear the watchdog, go to ISSUE.
  - ISSUE: drive `mem_addr`/`mem_wdata` from issue registers. `mem_re = !we && !mem_ready`; `mem_we = we && !mem_ready`. Both are masked combinationally in the `mem_ready` cycle so the controller, back in IDLE that cycle, does not re-launch.
    - On `mem_ready`: capture `mem_rdata` (loads) or 0 (stores) into `rsp_rdata`, `rsp_err=0`, go to RESP.
    - Else, when the watchdog reaches TIMEOUT-1: `rsp_err=1`, `rsp_rdata=0`, go to RESP.
    - `mem_ready` and timeout in the same cycle: `mem_ready` wins.
  - RESP: `rsp_valid=1`; response fields held stable. On `rsp_ready`, go to IDLE.
- A push and a pop in the same cycle leave the count unchanged.
- `mem_ready` outside ISSUE is ignored.
- Mid-operation reset: all state cleared immediately, FIFO emptied, in-flight request dropped with no response. `mem_re`/`mem_we` drop asynchronously.

## Timing
- Reset values: `req_ready`=0 while `reset` is high and 1 after; `rsp_valid`/`rsp_we`/`rsp_err`=0; `rsp_rdata`=0; `mem_re`/`mem_we`=0; `mem_addr`/`mem_wdata`=0; `fifo_count`=0; state=IDLE.
- Push into an empty FIFO at edge N → IDLE pops at edge N+1 → `mem_re`/`mem_we` high from cycle N+1 to N+2.
- `mem_ready` in cycle M → `rsp_valid` high from edge M+1.
- `rsp_ready` in the first RESP cycle → IDLE next cycle → the next request issues 1 cycle later. Minimum gap between consecutive `mem_re`/`mem_we` assertions is 2 cycles.
- Watchdog counts ISSUE cycles from 0. Abort takes effect at the edge after count TIMEOUT-1, after exactly TIMEOUT ISSUE cycles.
- Throughput: at most one request in flight; FIFO absorbs bursts up to DEPTH.

## Structure
- Package `cache_pkg`: ADDRESSLENGTH/DATALENGTH constants, FSM state enum (IDLE, ISSUE, RESP), request struct {we, addr, wdata}.
- Sub-module `req_fifo`: parameterised synchronous FIFO of the request struct with push/pop/full/empty/count. Issuer contains the FSM, watchdog, and response registers.

## Test plan
- Single load to 0x0040; model asserts `mem_ready` 3 cycles after `mem_re`, with `mem_rdata`=0xDEADBEEF → `rsp_valid`, `rsp_we`=0, `rsp_rdata`=0xDEADBEEF, `rsp_err`=0. `mem_re` is low in the `mem_ready` cycle.
- Store 0x12345678 to 0x0100 → `mem_we` high with `mem_addr`=0x0100 until `mem_ready`. Response has `rsp_we`=1, `rsp_rdata`=0.
- 6 back-to-back pushes with a stalled controller and DEPTH=4 → `req_ready` drops after the 4th accepted entry plus the one popped into ISSUE. All accepted requests are issued in order once the controller resumes; `fifo_count` never exceeds 4.
- Controller never pulses `mem_ready` → after exactly 64 ISSUE cycles, `rsp_valid` with `rsp_err`=1. The next queued request then issues normally.
- `rsp_ready` held low for 10 cycles → response fields stable, no new `mem_re`/`mem_we` issued. Pushes still accepted until full.
- `reset` asserted mid-ISSUE with 2 entries queued → `mem_re`=0 and `fifo_count`=0 immediately. No response after reset is released.

Source files
------------

// File: rtl/cache_req_issuer_pkg.sv
// Shared definitions for the cache request issuer.
//   ADDRESSLENGTH / DATALENGTH : default bus widths
//   state_t                    : issuer FSM states
//   req_t                      : one buffered CPU request (we, addr, wdata)
package cache_pkg;

    localparam int ADDRESSLENGTH = 16;
    localparam int DATALENGTH    = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // The request struct fixes its field widths to the package constants,
    // so instances keep ADDRESSLENGTH/DATALENGTH at these defaults.
    typedef struct packed {
        logic                     we;
        logic [ADDRESSLENGTH-1:0] addr;
        logic [DATALENGTH-1:0]    wdata;
    } req_t;

endpackage

// File: rtl/cache_req_issuer_if.sv
// Bundle of every non-clock signal of cache_req_issuer.
//   req_*      : CPU request handshake (valid/ready, we, addr, wdata)
//   rsp_*      : response handshake (valid/ready, we, rdata, err)
//   mem_*      : level interface to cache_controller (re/we/addr/wdata in,
//                rdata/ready pulse back)
//   fifo_count : occupancy of the request FIFO
// Modport slave is the issuer's view; modport master is its environment.
interface cache_req_issuer_if
    import cache_pkg::*;
#(
    parameter int ADDRESSLENGTH = cache_pkg::ADDRESSLENGTH,
    parameter int DATALENGTH    = cache_pkg::DATALENGTH,
    parameter int DEPTH         = 4
);
    localparam int COUNT_W = $clog2(DEPTH) + 1;

    logic                     req_valid;
    logic                     req_ready;
    logic                     req_we;
    logic [ADDRESSLENGTH-1:0] req_addr;
    logic [DATALENGTH-1:0]    req_wdata;

    logic                     rsp_valid;
    logic                     rsp_ready;
    logic                     rsp_we;
    logic [DATALENGTH-1:0]    rsp_rdata;
    logic                     rsp_err;

    logic                     mem_re;
    logic                     mem_we;
    logic [ADDRESSLENGTH-1:0] mem_addr;
    logic [DATALENGTH-1:0]    mem_wdata;
    logic [DATALENGTH-1:0]    mem_rdata;
    logic                     mem_ready;

    logic [COUNT_W-1:0]       fifo_count;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        input  rsp_ready,
        input  mem_rdata, mem_ready,
        output req_ready,
        output rsp_valid, rsp_we, rsp_rdata, rsp_err,
        output mem_re, mem_we, mem_addr, mem_wdata,
        output fifo_count
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        output rsp_ready,
        output mem_rdata, mem_ready,
        input  req_ready,
        input  rsp_valid, rsp_we, rsp_rdata, rsp_err,
        input  mem_re, mem_we, mem_addr, mem_wdata,
        input  fifo_count
    );

endinterface

// File: rtl/cache_req_issuer_fifo.sv
// req_fifo: synchronous FIFO of req_t entries.
//   clk, reset : clock, asynchronous active-high reset (empties the FIFO)
//   push       : write push_data (ignored when full)
//   pop        : advance past head (ignored when empty)
//   head       : oldest entry, valid while !empty
//   full/empty : derived from registered pointers only
//   count      : number of occupied entries
// Pointers carry one extra wrap bit: equal pointers mean empty, equal low
// bits with differing wrap bits mean full.
module req_fifo
    import cache_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int PW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  req_t          push_data,
    input  logic          pop,
    output req_t          head,
    output logic          full,
    output logic          empty,
    output logic [PW-1:0] count
);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    req_t          mem [DEPTH];

    logic do_push;
    logic do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign count   = wr_ptr - rd_ptr;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; an entry is only ever read
    // after it has been written, and the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/cache_req_issuer.sv
// cache_req_issuer: upstream stage of cache_controller.
//   clk   : single clock, rising edge
//   reset : asynchronous, active-high; drops any in-flight request
//   bus   : cache_req_issuer_if.slave
//           req_*  -> buffered in req_fifo (DEPTH entries)
//           mem_*  <- one request at a time, held until the mem_ready pulse
//           rsp_*  -> result of each request, held until rsp_ready
// A watchdog aborts a request after TIMEOUT ISSUE cycles without mem_ready
// and answers it with rsp_err=1.
module cache_req_issuer
    import cache_pkg::*;
#(
    parameter int ADDRESSLENGTH = cache_pkg::ADDRESSLENGTH,
    parameter int DATALENGTH    = cache_pkg::DATALENGTH,
    parameter int DEPTH         = 4,
    parameter int TIMEOUT       = 64
) (
    input  logic              clk,
    input  logic              reset,
    cache_req_issuer_if.slave bus
);

    localparam int                WD_W    = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT - 1);
    localparam int                COUNT_W = $clog2(DEPTH) + 1;

    // ---------------------------------------------------------------
    // Request FIFO
    // ---------------------------------------------------------------
    req_t               fifo_in;
    req_t               fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;
    logic [COUNT_W-1:0] fifo_cnt;

    assign fifo_in = '{we: bus.req_we, addr: bus.req_addr, wdata: bus.req_wdata};

    req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (bus.req_valid),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_cnt)
    );

    // req_ready comes from registered pointers only, so a full FIFO never
    // accepts even when a pop happens in the same cycle. It is held low while
    // reset is asserted.
    assign bus.req_ready  = !fifo_full && !reset;
    assign bus.fifo_count = fifo_cnt;

    // ---------------------------------------------------------------
    // Issuer FSM, issue registers, watchdog and response registers
    // ---------------------------------------------------------------
    state_t                state,      state_nxt;
    req_t                  iss,        iss_nxt;
    logic [WD_W-1:0]       wdog,       wdog_nxt;
    logic                  rsp_we_q,   rsp_we_nxt;
    logic                  rsp_err_q,  rsp_err_nxt;
    logic [DATALENGTH-1:0] rsp_rdata_q, rsp_rdata_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            iss         <= '0;
            wdog        <= '0;
            rsp_we_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state       <= state_nxt;
            iss         <= iss_nxt;
            wdog        <= wdog_nxt;
            rsp_we_q    <= rsp_we_nxt;
            rsp_err_q   <= rsp_err_nxt;
            rsp_rdata_q <= rsp_rdata_nxt;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt     = state;
        iss_nxt       = iss;
        wdog_nxt      = wdog;
        rsp_we_nxt    = rsp_we_q;
        rsp_err_nxt   = rsp_err_q;
        rsp_rdata_nxt = rsp_rdata_q;
        fifo_pop      = 1'b0;

        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    iss_nxt   = fifo_head;
                    wdog_nxt  = '0;
                    state_nxt = ISSUE;
                end
            end

            ISSUE: begin
                // mem_ready takes priority over a simultaneous timeout.
                if (bus.mem_ready) begin
                    rsp_we_nxt    = iss.we;
                    rsp_err_nxt   = 1'b0;
                    rsp_rdata_nxt = iss.we ? '0 : bus.mem_rdata;
                    state_nxt     = RESP;
                end else if (wdog == WD_LAST) begin
                    rsp_we_nxt    = iss.we;
                    rsp_err_nxt   = 1'b1;
                    rsp_rdata_nxt = '0;
                    state_nxt     = RESP;
                end else begin
                    wdog_nxt = wdog + 1'b1;
                end
            end

            RESP: begin
                if (bus.rsp_ready) state_nxt = IDLE;
            end

            default: state_nxt = IDLE;
        endcase
    end

    // Strobes are masked in the mem_ready cycle: the controller is back in
    // its IDLE that cycle and would otherwise launch the request again.
    // Because state resets asynchronously, the strobes also drop at once.
    assign bus.mem_re    = (state == ISSUE) && !iss.we && !bus.mem_ready;
    assign bus.mem_we    = (state == ISSUE) &&  iss.we && !bus.mem_ready;
    assign bus.mem_addr  = ADDRESSLENGTH'(iss.addr);
    assign bus.mem_wdata = DATALENGTH'(iss.wdata);

    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_we    = rsp_we_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule
